// File: rtl/byte_bus_responder.sv
// byte_bus_responder: 32-byte store behind the byte computer's bus, with loader, run control and run statistics.
// Define BYTE_BUS_RESP_DUMP_EN to stream the store out on dump_* after every halt.
module byte_bus_responder #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8,
   parameter int CYC_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] bus_addr,
   input  logic              bus_we,
   input  logic [DATA_W-1:0] bus_wdata,
   output logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_halt,
   output logic              cpu_start,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   input  logic              go,
   output logic              done,
   output logic [CYC_W-1:0]  run_cycles,
   output logic [DATA_W-1:0] wr_count,
   output logic              dump_valid,
   output logic [DATA_W-1:0] dump_data,
   input  logic              dump_ready
);
   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic [2:0] {IDLE, LOAD, ARMED, RUN, HALTED} state_t;

   state_t            r_state, w_next;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0] r_ptr, w_waddr;
   logic              r_live, r_start, r_done;
   logic [CYC_W-1:0]  r_cyc;
   logic [DATA_W-1:0] r_wr;
   logic              w_xfer, w_bus_wr, w_enter_run;

   // r_live keeps the loader stalled until the first edge after reset release
   assign ld_ready    = r_live && (r_state == IDLE || r_state == LOAD);
   assign w_xfer      = ld_valid && ld_ready;
   assign w_bus_wr    = (r_state == RUN) && bus_we;
   assign w_enter_run = (w_next == RUN) && (r_state != RUN);
   assign w_waddr     = w_bus_wr ? bus_addr : (r_state == IDLE ? '0 : r_ptr);
   assign bus_rdata   = r_mem[bus_addr];
   assign cpu_start   = r_start;
   assign done        = r_done;
   assign run_cycles  = r_cyc;
   assign wr_count    = r_wr;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_xfer ? (ld_last ? ARMED : LOAD) : (go ? RUN : IDLE);
         LOAD:    w_next = (w_xfer && (ld_last || r_ptr == '1)) ? ARMED : LOAD;
         ARMED:   w_next = go ? RUN : ARMED;
         RUN:     w_next = bus_halt ? HALTED : RUN;
         HALTED:  w_next = go ? RUN : HALTED;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_live  <= 1'b0;
         r_start <= 1'b0;
         r_done  <= 1'b0;
         r_cyc   <= '0;
         r_wr    <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         r_state <= w_next;
         r_live  <= 1'b1;
         r_start <= (w_next == RUN);
         r_done  <= (w_next == HALTED);
         if (w_bus_wr || w_xfer) r_mem[w_waddr] <= w_bus_wr ? bus_wdata : ld_data;
         if (w_xfer) r_ptr <= w_waddr + 1'b1;
         if (w_enter_run) begin
            r_cyc <= '0;
            r_wr  <= '0;
         end else if (r_state == RUN) begin
            if (r_cyc != '1) r_cyc <= r_cyc + 1'b1;
            if (bus_we) r_wr <= r_wr + 1'b1;
         end
      end
   end

`ifdef BYTE_BUS_RESP_DUMP_EN
   logic              r_dump_valid, r_dump_pend;
   logic [ADDR_W-1:0] r_dump_ptr;

   // the store is frozen in HALTED, so reading it through r_dump_ptr holds dump_data stable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dump_valid <= 1'b0;
         r_dump_pend  <= 1'b0;
         r_dump_ptr   <= '0;
      end else if (w_enter_run) begin
         r_dump_valid <= 1'b0;
         r_dump_pend  <= 1'b0;
      end else if (r_state == RUN && w_next == HALTED) begin
         r_dump_pend <= 1'b1;
         r_dump_ptr  <= '0;
      end else if (r_dump_pend) begin
         r_dump_pend  <= 1'b0;
         r_dump_valid <= 1'b1;
      end else if (r_dump_valid && dump_ready) begin
         r_dump_valid <= (r_dump_ptr != '1);
         r_dump_ptr   <= r_dump_ptr + 1'b1;
      end
   end

   assign dump_valid = r_dump_valid;
   assign dump_data  = r_dump_valid ? r_mem[r_dump_ptr] : '0;
`else
   logic w_unused;
   assign w_unused   = dump_ready;
   assign dump_valid = 1'b0;
   assign dump_data  = '0;
`endif
endmodule
